sevenseg_scan_ctrl: RTL

Sequences the 8-digit seven-segment display from the `display` word and `cfg` bits produced by the seven-segment AXI front-end. For decimal fields it converts binary to BCD with a sequential double-dabble engine. It holds the resulting digit codes in a display buffer and time-multiplexes the anodes at a fixed refresh rate. It sits between the AXI front-end and the board's anode/cathode pins.

---
 rtl/sevenseg_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
//   Drives an 8-digit multiplexed seven-segment display from a 32-bit value
//   word and a 3-bit format word. Decimal fields are converted to BCD by a
//   sequential double-dabble engine (one shift per clock). Results are staged
//   in a shadow buffer and copied to the display buffer in a single clock, so
//   the scanner never shows a half-finished conversion.
//
// Ports
//   clk       system clock
//   resetn    asynchronous active-low reset
//   display   raw value: one 32-bit field, or {left[15:0], right[15:0]}
//   cfg       bit0 split mode, bit1 single/right decimal, bit2 left decimal
//   anode     active-low digit enables, bit 0 = rightmost digit
//   cathode   active-low segments {dp,g,f,e,d,c,b,a}; dp is always off
//   busy      high while the converter is outside IDLE
//   state_dbg converter FSM state (IDLE=0, SETUP=1, CONV=2, LATCH=3)
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits of each field
//                          are blanked at latch time (ones digit always shown).

module sevenseg_scan_ctrl #(
    parameter int CLK_FREQ = 100000000,
    parameter int DIGIT_HZ = 8000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] display,
    input  logic [2:0]  cfg,
    output logic [7:0]  anode,
    output logic [7:0]  cathode,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int TPD = CLK_FREQ / DIGIT_HZ;
    localparam int PW  = (TPD > 1) ? $clog2(TPD) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TPD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_CONV  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    localparam logic [4:0] CODE_BLANK = 5'h10;
    localparam logic [4:0] CODE_DASH  = 5'h11;

    logic [1:0]    state;
    logic [31:0]   snap_display;
    logic [2:0]    snap_cfg;
    logic          pending;
    logic [4:0]    shadow [8];
    logic [4:0]    buffer [8];
    logic [4:0]    latch_buf [8];
    logic [39:0]   bcd;
    logic [31:0]   bin;
    logic [39:0]   bcd_adj;
    logic [39:0]   bcd_next;
    logic [31:0]   bin_next;
    logic [4:0]    shift_cnt;
    logic          phase;       // 0 = converting right half, 1 = left half
    logic          last_shift;
    logic [PW-1:0] prescale;
    logic [2:0]    digit_idx;

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'h00:   seg_decode = 7'b1000000;
            5'h01:   seg_decode = 7'b1111001;
            5'h02:   seg_decode = 7'b0100100;
            5'h03:   seg_decode = 7'b0110000;
            5'h04:   seg_decode = 7'b0011001;
            5'h05:   seg_decode = 7'b0010010;
            5'h06:   seg_decode = 7'b0000010;
            5'h07:   seg_decode = 7'b1111000;
            5'h08:   seg_decode = 7'b0000000;
            5'h09:   seg_decode = 7'b0010000;
            5'h0A:   seg_decode = 7'b0001000;
            5'h0B:   seg_decode = 7'b0000011;
            5'h0C:   seg_decode = 7'b1000110;
            5'h0D:   seg_decode = 7'b0100001;
            5'h0E:   seg_decode = 7'b0000110;
            5'h0F:   seg_decode = 7'b0001110;
            5'h11:   seg_decode = 7'b0111111;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Double-dabble step: correct every BCD nibble >= 5, then shift the
    // binary MSB into the BCD accumulator.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[38:0], bin[31]};
        bin_next = {bin[30:0], 1'b0};
    end

    assign last_shift = (shift_cnt == (snap_cfg[0] ? 5'd15 : 5'd31));
    assign busy       = (state != S_IDLE);
    assign state_dbg  = state;

    // Final digit codes for the latch step: overflow dashes, then optional
    // leading-zero blanking.
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic lead;
`endif
        for (int i = 0; i < 8; i++) begin
            latch_buf[i] = shadow[i];
        end
        if (!snap_cfg[0]) begin
            if (snap_cfg[1] && snap_display > 32'd99999999) begin
                for (int i = 0; i < 8; i++) latch_buf[i] = CODE_DASH;
            end
        end else begin
            if (snap_cfg[1] && snap_display[15:0] > 16'd9999) begin
                for (int i = 0; i < 4; i++) latch_buf[i] = CODE_DASH;
            end
            if (snap_cfg[2] && snap_display[31:16] > 16'd9999) begin
                for (int i = 4; i < 8; i++) latch_buf[i] = CODE_DASH;
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            if (snap_cfg[0] && i == 4) begin
                // digit 4 is the left field's ones digit; right field starts below
                lead = 1'b1;
            end else if (lead && latch_buf[i] == 5'h00) begin
                latch_buf[i] = CODE_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
`endif
    end

    // Converter FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            snap_display <= '0;
            snap_cfg     <= '0;
            pending      <= 1'b1;
            bcd          <= '0;
            bin          <= '0;
            shift_cnt    <= '0;
            phase        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= CODE_BLANK;
                buffer[i] <= CODE_BLANK;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending || {display, cfg} != {snap_display, snap_cfg}) begin
                        snap_display <= display;
                        snap_cfg     <= cfg;
                        pending      <= 1'b0;
                        state        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    shift_cnt <= '0;
                    bcd       <= '0;
                    if (!snap_cfg[0]) begin
                        phase <= 1'b0;
                        if (snap_cfg[1]) begin
                            bin   <= snap_display;
                            state <= S_CONV;
                        end else begin
                            for (int i = 0; i < 8; i++) begin
                                shadow[i] <= {1'b0, snap_display[4*i +: 4]};
                            end
                            state <= S_LATCH;
                        end
                    end else begin
                        if (!snap_cfg[1]) begin
                            for (int i = 0; i < 4; i++) begin
                                shadow[i] <= {1'b0, snap_display[4*i +: 4]};
                            end
                        end
                        if (!snap_cfg[2]) begin
                            for (int i = 0; i < 4; i++) begin
                                shadow[i+4] <= {1'b0, snap_display[16+4*i +: 4]};
                            end
                        end
                        // Right half converts first; a hex right half is skipped.
                        phase <= !snap_cfg[1];
                        bin   <= snap_cfg[1] ? {snap_display[15:0], 16'h0000}
                                             : {snap_display[31:16], 16'h0000};
                        state <= (snap_cfg[1] || snap_cfg[2]) ? S_CONV : S_LATCH;
                    end
                end
                S_CONV: begin
                    bcd       <= bcd_next;
                    bin       <= bin_next;
                    shift_cnt <= shift_cnt + 5'd1;
                    if (last_shift) begin
                        if (!snap_cfg[0]) begin
                            for (int i = 0; i < 8; i++) shadow[i] <= {1'b0, bcd_next[4*i +: 4]};
                        end else if (!phase) begin
                            for (int i = 0; i < 4; i++) shadow[i] <= {1'b0, bcd_next[4*i +: 4]};
                        end else begin
                            for (int i = 0; i < 4; i++) shadow[i+4] <= {1'b0, bcd_next[4*i +: 4]};
                        end
                        if (snap_cfg[0] && !phase && snap_cfg[2]) begin
                            phase     <= 1'b1;
                            bcd       <= '0;
                            bin       <= {snap_display[31:16], 16'h0000};
                            shift_cnt <= '0;
                        end else begin
                            state <= S_LATCH;
                        end
                    end
                end
                default: begin
                    for (int i = 0; i < 8; i++) buffer[i] <= latch_buf[i];
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Scanner: free-running, independent of the converter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescale  <= '0;
            digit_idx <= '0;
            anode     <= 8'hFF;
            cathode   <= 8'hFF;
        end else begin
            if (prescale == PRE_MAX) begin
                prescale  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                prescale <= prescale + 1'b1;
            end
            anode   <= ~(8'b1 << digit_idx);
            cathode <= {1'b1, seg_decode(buffer[digit_idx])};
        end
    end

endmodule
